rgb_to_ycbcr_pipe: RTL and testbench
====================================

Name: rgb_to_ycbcr_pipe

Overview:
Parametrised, pipelined colour-space converter from RGB to YCbCr. It is the successor to the fixed 8-bit converter.
- Generalised sample width.
- Per-pixel selectable BT.601 / BT.709 full-range coefficients.
- Valid/ready streaming with backpressure.
- Frame-end sideband and an output beat counter.

It sits between the camera/frame-reader front end and the skin-segmentation stage of the gesture pipeline.

Parameters:
- DATA_W, 8, bits per colour sample (in and out); legal 8..12.
- FRAC_W, 14, fractional bits of the fixed-point coefficients.
- CNT_W, 24, width of the output beat counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- red_ch  in  DATA_W  red sample.
- green_ch  in  DATA_W  green sample.
- blue_ch  in  DATA_W  blue sample.
- std_sel  in  1  0 = BT.601, 1 = BT.709; sampled with each accepted beat.
- in_last  in  1  marks the last pixel of a frame.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- luma_ch  out  DATA_W  Y.
- cb_ch  out  DATA_W  Cb.
- cr_ch  out  DATA_W  Cr.
- out_last  out  1  in_last delayed with its pixel.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- beat_cnt  out  CNT_W  number of output beats transferred since reset.

Behaviour:
- Reset is synchronous, active-high, and applied on clk edge with rst=1. Reset values:
  - out_valid = 0; all internal stage valids = 0.
  - luma_ch, cb_ch, cr_ch = 0; out_last = 0; beat_cnt = 0.
  - in_ready = 1 from the first cycle after reset.
- Reset mid-stream drops all in-flight beats. No partial output appears afterwards.
- Pipeline: three stages, S1 → S2 → S3. S3 drives the outputs.
- Global enable en = ~(out_valid & ~out_ready); in_ready = en.
  - When en=1, every stage advances: valid, data, std_sel and last shift one stage.
  - When en=0, all stages hold.
  - Bubbles are not collapsed.
- Input accept: in_valid & in_ready.
- Output transfer: out_valid & out_ready.
- Latency: a beat accepted on edge N is presented on outputs after edge N+2, given no stall. Throughput is one pixel per clock.
- Outputs are stable while out_valid=1 and out_ready=0.
- Coefficients: signed, scaled by 2^14 (FRAC_W=14). For other FRAC_W values, round(c·2^FRAC_W) is computed at elaboration.
  - BT.601 Y: 4899, 9617, 1868.
  - BT.601 Cb: -2765, -5427, 8192.
  - BT.601 Cr: 8192, -6860, -1332.
  - BT.709 Y: 3483, 11718, 1183.
  - BT.709 Cb: -1877, -6315, 8192.
  - BT.709 Cr: 8192, -7441, -751.
  - In each triple, the order is R, G, B multipliers.
  - Each Y triple sums to 2^FRAC_W. Each Cb and Cr triple sums to 0, with half-scale positive and negative parts.
- S1: nine signed products (sample zero-extended × coefficient), coefficient set selected by that beat's std_sel.
- S2: per channel, sum the three products and add the rounding constant 2^(FRAC_W-1).
  - Cb and Cr also add the offset 2^(DATA_W-1)·2^FRAC_W.
  - The accumulator is wide enough to never overflow: DATA_W+FRAC_W+3 bits, signed.
- S3: arithmetic shift right by FRAC_W (floor), then clamp to [0, 2^DATA_W-1].
- std_sel may change on every beat. Each pixel uses the value captured with it.
- beat_cnt increments by 1 on each output transfer and wraps modulo 2^CNT_W.
- Simultaneous input accept and output transfer in the same cycle is the normal streaming case. No beat is lost or duplicated.

Test Plan:
1. Reset, then stream R,G,B = 255,255,255 (BT.601), out_ready=1 → after 3 cycles Y,Cb,Cr = 255,128,128. Black (0,0,0) gives 0,128,128. beat_cnt = 2 after both transfers.
2. Red (255,0,0), std_sel=0 → Y = 76, Cb = 85, Cr = 255 (clamped from 256).
3. Blue (0,0,255), std_sel=1 → Y = 18, Cb = 255 (clamped), Cr = 116. Interleave with item 2 beat-by-beat and check per-pixel coefficient selection.
4. Continuous stream of 10 beats with out_ready = 0 for cycles 4–7:
   - in_ready drops the same cycle as the stall, and the held output stays stable.
   - All 10 beats emerge in order, with no loss or duplication.
   - out_last asserted only on beat 10.
5. Assert rst while 3 beats are in flight → the next cycle has out_valid = 0 and beat_cnt = 0. No stale pixel appears afterwards.
6. CNT_W = 4: transfer 17 beats → beat_cnt = 1 (wrap). DATA_W = 10 with input 1023,1023,1023 (BT.709) → 1023,512,512.

Source files
------------

// File: rtl/rgb_to_ycbcr_pipe.sv
// Three-stage RGB -> YCbCr converter (BT.601 / BT.709 full range).
// Stream interface is valid/ready; a single global enable stalls all stages together.
module rgb_to_ycbcr_pipe #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 14,
  parameter int CNT_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] red_ch,
  input  logic [DATA_W-1:0] green_ch,
  input  logic [DATA_W-1:0] blue_ch,
  input  logic              std_sel,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] luma_ch,
  output logic [DATA_W-1:0] cb_ch,
  output logic [DATA_W-1:0] cr_ch,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  beat_cnt
);

  localparam int CW    = FRAC_W + 2;
  localparam int ACC_W = DATA_W + FRAC_W + 3;

  function automatic logic signed [CW-1:0] coef(input real c);
    real scaled;
    scaled = c * (2.0 ** FRAC_W);
    if (scaled < 0.0) begin
      return CW'($rtoi(scaled - 0.5));
    end else begin
      return CW'($rtoi(scaled + 0.5));
    end
  endfunction

  localparam logic signed [CW-1:0] C601_YR  = coef(0.299);
  localparam logic signed [CW-1:0] C601_YG  = coef(0.587);
  localparam logic signed [CW-1:0] C601_YB  = coef(0.114);
  localparam logic signed [CW-1:0] C601_CBR = coef(-0.168736);
  localparam logic signed [CW-1:0] C601_CBG = coef(-0.331264);
  localparam logic signed [CW-1:0] C601_CBB = coef(0.5);
  localparam logic signed [CW-1:0] C601_CRR = coef(0.5);
  localparam logic signed [CW-1:0] C601_CRG = coef(-0.418688);
  localparam logic signed [CW-1:0] C601_CRB = coef(-0.081312);
  localparam logic signed [CW-1:0] C709_YR  = coef(0.2126);
  localparam logic signed [CW-1:0] C709_YG  = coef(0.7152);
  localparam logic signed [CW-1:0] C709_YB  = coef(0.0722);
  localparam logic signed [CW-1:0] C709_CBR = coef(-0.114572);
  localparam logic signed [CW-1:0] C709_CBG = coef(-0.385428);
  localparam logic signed [CW-1:0] C709_CBB = coef(0.5);
  localparam logic signed [CW-1:0] C709_CRR = coef(0.5);
  localparam logic signed [CW-1:0] C709_CRG = coef(-0.454153);
  localparam logic signed [CW-1:0] C709_CRB = coef(-0.045847);

  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(64'sd1 <<< (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] OFS  = ACC_W'(64'sd1 <<< (DATA_W - 1 + FRAC_W));
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'sd1 <<< DATA_W) - 64'sd1);

  // Floor shift out the fraction, then saturate into the unsigned sample range.
  function automatic logic [DATA_W-1:0] clamp(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC_W;
    if (s[ACC_W-1]) begin
      return '0;
    end else if (s > MAXV) begin
      return '1;
    end else begin
      return s[DATA_W-1:0];
    end
  endfunction

  logic                    w_en;
  logic signed [CW-1:0]    w_k   [9];
  logic signed [ACC_W-1:0] w_smp [3];

  logic                    r_s1_valid;
  logic                    r_s1_last;
  logic signed [ACC_W-1:0] r_p [9];
  logic                    r_s2_valid;
  logic                    r_s2_last;
  logic signed [ACC_W-1:0] r_acc_y;
  logic signed [ACC_W-1:0] r_acc_cb;
  logic signed [ACC_W-1:0] r_acc_cr;
  logic                    r_out_valid;
  logic                    r_out_last;
  logic [DATA_W-1:0]       r_luma;
  logic [DATA_W-1:0]       r_cb;
  logic [DATA_W-1:0]       r_cr;
  logic [CNT_W-1:0]        r_cnt;

  // Only a held, unaccepted output beat can stall the pipe.
  assign w_en     = ~(r_out_valid & ~out_ready);
  assign in_ready = w_en;

  assign w_smp[0] = ACC_W'({1'b0, red_ch});
  assign w_smp[1] = ACC_W'({1'b0, green_ch});
  assign w_smp[2] = ACC_W'({1'b0, blue_ch});

  // Coefficient set follows the std_sel of the beat currently being accepted.
  always_comb begin
    if (std_sel) begin
      w_k[0] = C709_YR;  w_k[1] = C709_YG;  w_k[2] = C709_YB;
      w_k[3] = C709_CBR; w_k[4] = C709_CBG; w_k[5] = C709_CBB;
      w_k[6] = C709_CRR; w_k[7] = C709_CRG; w_k[8] = C709_CRB;
    end else begin
      w_k[0] = C601_YR;  w_k[1] = C601_YG;  w_k[2] = C601_YB;
      w_k[3] = C601_CBR; w_k[4] = C601_CBG; w_k[5] = C601_CBB;
      w_k[6] = C601_CRR; w_k[7] = C601_CRG; w_k[8] = C601_CRB;
    end
  end

  // Pipeline: S1 products, S2 rounded/offset sums, S3 shift+clamp into outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_last   <= 1'b0;
      r_acc_y     <= '0;
      r_acc_cb    <= '0;
      r_acc_cr    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_luma      <= '0;
      r_cb        <= '0;
      r_cr        <= '0;
      for (int j = 0; j < 9; j++) begin
        r_p[j] <= '0;
      end
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_last <= in_last;
        for (int j = 0; j < 9; j++) begin
          r_p[j] <= w_smp[j % 3] * ACC_W'(w_k[j]);
        end
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_last <= r_s1_last;
        r_acc_y   <= r_p[0] + r_p[1] + r_p[2] + RND;
        r_acc_cb  <= r_p[3] + r_p[4] + r_p[5] + RND + OFS;
        r_acc_cr  <= r_p[6] + r_p[7] + r_p[8] + RND + OFS;
      end
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_last <= r_s2_last;
        r_luma     <= clamp(r_acc_y);
        r_cb       <= clamp(r_acc_cb);
        r_cr       <= clamp(r_acc_cr);
      end
    end
  end

  // Output transfer counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_out_valid && out_ready) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign luma_ch   = r_luma;
  assign cb_ch     = r_cb;
  assign cr_ch     = r_cr;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;
  assign beat_cnt  = r_cnt;

endmodule

// File: tb/tb_rgb_to_ycbcr_pipe.sv
// Randomised scoreboard bench for rgb_to_ycbcr_pipe, plus a 10-bit / 4-bit-counter instance.
module tb_rgb_to_ycbcr_pipe;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic       last;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  red_ch = 8'd0, green_ch = 8'd0, blue_ch = 8'd0;
  logic        std_sel = 1'b0, in_last = 1'b0, in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  luma_ch, cb_ch, cr_ch;
  logic        out_last, out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] beat_cnt;

  logic [9:0]  b_r = 10'd0, b_g = 10'd0, b_b = 10'd0;
  logic        b_std = 1'b0, b_last = 1'b0, b_valid = 1'b0;
  logic        b_in_ready;
  logic [9:0]  b_luma, b_cb, b_cr;
  logic        b_out_last, b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [3:0]  b_cnt;

  int          n_total = 0;
  int          n_pass  = 0;
  pix_t        q[$];
  pix_t        cur_exp = '0;
  logic [23:0] exp_cnt = 24'd0;
  bit          rand_ready = 1'b0;

  always #5 clk = ~clk;

  rgb_to_ycbcr_pipe dut (
    .clk(clk), .rst(rst), .red_ch(red_ch), .green_ch(green_ch), .blue_ch(blue_ch),
    .std_sel(std_sel), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .luma_ch(luma_ch), .cb_ch(cb_ch), .cr_ch(cr_ch), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .beat_cnt(beat_cnt)
  );

  rgb_to_ycbcr_pipe #(.DATA_W(10), .FRAC_W(14), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .red_ch(b_r), .green_ch(b_g), .blue_ch(b_b),
    .std_sel(b_std), .in_last(b_last), .in_valid(b_valid), .in_ready(b_in_ready),
    .luma_ch(b_luma), .cb_ch(b_cb), .cr_ch(b_cr), .out_last(b_out_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .beat_cnt(b_cnt)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: full-range YCbCr from the published coefficient table, 8-bit samples.
  function automatic pix_t model(input int r, input int g, input int b, input bit std, input bit last);
    int k[3][3];
    int acc;
    int v[3];
    pix_t p;
    if (!std) k = '{'{4899, 9617, 1868}, '{-2765, -5427, 8192}, '{8192, -6860, -1332}};
    else      k = '{'{3483, 11718, 1183}, '{-1877, -6315, 8192}, '{8192, -7441, -751}};
    for (int c = 0; c < 3; c++) begin
      acc = k[c][0] * r + k[c][1] * g + k[c][2] * b + 8192 + ((c == 0) ? 0 : 128 * 16384);
      acc = acc >>> 14;
      v[c] = (acc < 0) ? 0 : ((acc > 255) ? 255 : acc);
    end
    p.y = v[0][7:0]; p.cb = v[1][7:0]; p.cr = v[2][7:0]; p.last = last;
    return p;
  endfunction

  function automatic pix_t mk(input int y, input int cb, input int cr, input bit last);
    pix_t p;
    p.y = y[7:0]; p.cb = cb[7:0]; p.cr = cr[7:0]; p.last = last;
    return p;
  endfunction

  task automatic send(input int r, input int g, input int b, input bit std, input bit last, input pix_t e);
    bit ok;
    red_ch = r[7:0]; green_ch = g[7:0]; blue_ch = b[7:0];
    std_sel = std; in_last = last; cur_exp = e; in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_rand(input bit last);
    int r, g, b;
    bit s;
    r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
    s = 1'($urandom_range(0, 1));
    send(r, g, b, s, last, model(r, g, b, s, last));
  endtask

  // Scoreboard: samples handshakes at the falling edge, before they take effect.
  initial begin
    pix_t f;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        exp_cnt = 24'd0;
      end else begin
        chk("beat_cnt", beat_cnt, exp_cnt);
        chk("in_ready", in_ready, !(out_valid && !out_ready));
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            f = q[0];
            chk("luma", luma_ch, f.y);
            chk("cb", cb_ch, f.cb);
            chk("cr", cr_ch, f.cr);
            chk("out_last", out_last, f.last);
            if (out_ready) begin
              void'(q.pop_front());
              exp_cnt = exp_cnt + 24'd1;
            end
          end
        end
        if (in_valid && in_ready) q.push_back(cur_exp);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_luma", luma_ch, 0);
    chk("rst_cb", cb_ch, 0);
    chk("rst_cr", cr_ch, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    send(255, 255, 255, 1'b0, 1'b0, mk(255, 128, 128, 1'b0));
    send(0, 0, 0, 1'b0, 1'b0, mk(0, 128, 128, 1'b0));
    idle(5);
    chk("cnt_after_two", beat_cnt, 2);

    for (int i = 0; i < 4; i++) begin
      send(255, 0, 0, 1'b0, 1'b0, mk(76, 85, 255, 1'b0));
      send(0, 0, 255, 1'b1, 1'b0, mk(18, 255, 116, 1'b0));
    end
    idle(5);

    fork
      begin
        for (int i = 1; i <= 10; i++) send_rand(i == 10);
      end
      begin
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
    join
    idle(6);

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_beat_cnt", beat_cnt, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    idle(6);
    chk("no_stale_valid", out_valid, 0);

    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send_rand(1'($urandom_range(0, 7) == 0));
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (q.size() == 0) break;
      idle(1);
    end
    chk("drain_empty", q.size(), 0);

    b_r = 10'd1023; b_g = 10'd1023; b_b = 10'd1023; b_std = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      b_valid = 1'b1;
      b_last = (i == 17);
      @(posedge clk);
      #1;
    end
    b_valid = 1'b0;
    b_last = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("b_out_valid", b_out_valid, 0);
    chk("b_luma", b_luma, 1023);
    chk("b_cb", b_cb, 512);
    chk("b_cr", b_cr, 512);
    chk("b_out_last", b_out_last, 1);
    chk("b_cnt_wrap", b_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
